// File: rtl/clause_literal_driver.sv
// clause_literal_driver
// Brute-force assignment enumerator feeding a clause_evaluator. A programmable
// clause table (variable index + polarity per literal) is encoded against every
// assignment of NUM_VARS variables in turn. Bit = 1 means the literal is False.
// The search stops at the first assignment the evaluator reports as satisfying,
// or reports UNSAT after the last assignment has been checked.
module clause_literal_driver #(
   parameter int NUM_CLAUSES         = 16,
   parameter int NUM_VARS_PER_CLAUSE = 3,
   parameter int NUM_VARS            = 8,
   localparam int VAR_IDX_W   = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1,
   localparam int CLAUSE_W    = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1,
   localparam int LIT_W       = (NUM_VARS_PER_CLAUSE > 1) ? $clog2(NUM_VARS_PER_CLAUSE) : 1,
   localparam int INPUT_WIDTH = NUM_CLAUSES * NUM_VARS_PER_CLAUSE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_we,
   input  logic [CLAUSE_W-1:0]    cfg_clause,
   input  logic [LIT_W-1:0]       cfg_lit,
   input  logic [VAR_IDX_W-1:0]   cfg_var,
   input  logic                   cfg_neg,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   sat,
   output logic [NUM_VARS-1:0]    assignment,
   output logic [INPUT_WIDTH-1:0] clauses_out,
   input  logic                   unsatisfied_in
);

   // One-bit-wider limits so the range checks work even when a count is a power of two.
   localparam logic [CLAUSE_W:0]  CLAUSE_LIMIT = NUM_CLAUSES[CLAUSE_W:0];
   localparam logic [LIT_W:0]     LIT_LIMIT    = NUM_VARS_PER_CLAUSE[LIT_W:0];
   localparam logic [VAR_IDX_W:0] VAR_LIMIT    = NUM_VARS[VAR_IDX_W:0];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state, state_next;

   logic [VAR_IDX_W-1:0]   var_tbl [NUM_CLAUSES][NUM_VARS_PER_CLAUSE];
   logic                   neg_tbl [NUM_CLAUSES][NUM_VARS_PER_CLAUSE];
   logic [NUM_VARS-1:0]    counter;
   logic [INPUT_WIDTH-1:0] encoded;
   logic                   cfg_ok;

   // Table writes are accepted only outside a search and only for in-range fields.
   assign cfg_ok = cfg_we
                   && (state == S_IDLE || state == S_DONE)
                   && ({1'b0, cfg_clause} < CLAUSE_LIMIT)
                   && ({1'b0, cfg_lit}    < LIT_LIMIT)
                   && ({1'b0, cfg_var}    < VAR_LIMIT);

   assign busy = (state == S_DRIVE) || (state == S_CHECK);
   assign done = (state == S_DONE);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next-state logic: start only in IDLE, DONE lasts one cycle.
   always_comb begin
      // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
      state_next = state;
      unique case (state)
         S_IDLE:  if (start) state_next = S_DRIVE;
         S_DRIVE: state_next = S_CHECK;
         S_CHECK: begin
            if (!unsatisfied_in || counter == '1) state_next = S_DONE;
            else                                  state_next = S_DRIVE;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Clause table: written from the cfg port; a write coinciding with start lands before the first encode.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the table is a small register file whose cleared contents are visible behaviour, so it is reset.
         for (int c = 0; c < NUM_CLAUSES; c++) begin
            for (int l = 0; l < NUM_VARS_PER_CLAUSE; l++) begin
               var_tbl[c][l] <= '0;
               neg_tbl[c][l] <= 1'b0;
            end
         end
      end else if (cfg_ok) begin
         var_tbl[cfg_clause][cfg_lit] <= cfg_var;
         neg_tbl[cfg_clause][cfg_lit] <= cfg_neg;
      end
   end

   // Encode the current assignment: 1 marks a literal that evaluates False.
   always_comb begin
      encoded = '0;
      for (int c = 0; c < NUM_CLAUSES; c++) begin
         for (int l = 0; l < NUM_VARS_PER_CLAUSE; l++) begin
            encoded[c*NUM_VARS_PER_CLAUSE + l] = neg_tbl[c][l] ?  counter[var_tbl[c][l]]
                                                               : ~counter[var_tbl[c][l]];
         end
      end
   end

   // Search datapath: enumeration counter, registered literal vector and result.
   always_ff @(posedge clk) begin
      if (rst) begin
         counter     <= '0;
         sat         <= 1'b0;
         assignment  <= '0;
         clauses_out <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  counter    <= '0;
                  sat        <= 1'b0;
                  assignment <= '0;
               end
            end
            S_DRIVE: clauses_out <= encoded;
            S_CHECK: begin
               // Termination is tested before incrementing, so the counter never wraps.
               if (!unsatisfied_in) begin
                  sat        <= 1'b1;
                  assignment <= counter;
               end else if (counter == '1) begin
                  sat        <= 1'b0;
                  assignment <= '0;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_clause_literal_driver.sv
// Self-checking bench for clause_literal_driver. A behavioural stand-in for
// clause_evaluator closes the loop; a table-level model predicts the first
// satisfying assignment and the expected literal vectors.
module tb_clause_literal_driver;

   localparam int NC = 16;
   localparam int NL = 3;
   localparam int NV = 8;
   localparam int IW = NC * NL;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_we = 1'b0;
   logic [3:0]    cfg_clause = '0;
   logic [1:0]    cfg_lit = '0;
   logic [2:0]    cfg_var = '0;
   logic          cfg_neg = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, sat;
   logic [NV-1:0] assignment;
   logic [IW-1:0] clauses_out;
   logic          unsat;

   int checks = 0;
   int failures = 0;

   // Reference clause table.
   int m_var [NC][NL];
   bit m_neg [NC][NL];

   clause_literal_driver #(
      .NUM_CLAUSES(NC), .NUM_VARS_PER_CLAUSE(NL), .NUM_VARS(NV)
   ) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_clause(cfg_clause),
      .cfg_lit(cfg_lit), .cfg_var(cfg_var), .cfg_neg(cfg_neg), .start(start),
      .busy(busy), .done(done), .sat(sat), .assignment(assignment),
      .clauses_out(clauses_out), .unsatisfied_in(unsat)
   );

   always #5 clk = ~clk;

   // Evaluator stand-in: a clause is unsatisfied when all its literals are False.
   always_comb begin
      unsat = 1'b0;
      for (int c = 0; c < NC; c++)
         if (&clauses_out[c*NL +: NL]) unsat = 1'b1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_clear();
      for (int c = 0; c < NC; c++)
         for (int l = 0; l < NL; l++) begin
            m_var[c][l] = 0;
            m_neg[c][l] = 1'b0;
         end
   endfunction

   // Expected literal vector: literal value is x[var] xor neg; False is encoded as 1.
   function automatic logic [IW-1:0] model_encode(input int k);
      logic [IW-1:0] r;
      r = '0;
      for (int c = 0; c < NC; c++)
         for (int l = 0; l < NL; l++)
            r[c*NL + l] = !(((k >> m_var[c][l]) & 1) ^ int'(m_neg[c][l]));
      return r;
   endfunction

   // First assignment that satisfies every clause, or -1 if none.
   function automatic int model_solve();
      for (int k = 0; k < (1 << NV); k++) begin
         bit all_ok = 1'b1;
         for (int c = 0; c < NC; c++) begin
            bit any_true = 1'b0;
            for (int l = 0; l < NL; l++)
               if ((((k >> m_var[c][l]) & 1) ^ int'(m_neg[c][l])) == 1) any_true = 1'b1;
            if (!any_true) all_ok = 1'b0;
         end
         if (all_ok) return k;
      end
      return -1;
   endfunction

   function automatic void model_write(input int c, input int l, input int v, input bit n);
      if (c < NC && l < NL && v < NV) begin
         m_var[c][l] = v;
         m_neg[c][l] = n;
      end
   endfunction

   task automatic write_lit(input int c, input int l, input int v, input bit n);
      @(negedge clk);
      cfg_we = 1'b1; cfg_clause = 4'(c); cfg_lit = 2'(l); cfg_var = 3'(v); cfg_neg = n;
      model_write(c, l, v, n);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic set_clause(input int c, input int v0, input bit n0, input int v1,
                             input bit n1, input int v2, input bit n2);
      write_lit(c, 0, v0, n0);
      write_lit(c, 1, v1, n1);
      write_lit(c, 2, v2, n2);
   endtask

   // Start from IDLE; returns at the negedge after the accept edge.
   task automatic start_search(input string name);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || sat !== 1'b0 || assignment !== '0) begin
         failures++;
         $display("FAIL %s_accept: busy=%b sat=%b assignment=%h, required busy=1 sat=0 assignment=00",
                  name, busy, sat, assignment);
      end
   endtask

   // Follow a search to DONE, checking every driven vector, timing and result.
   // dist_edge >= 1 pulses cfg_we (clause 0, lit 0 := x0) and start at that edge.
   task automatic wait_done(input int exp_k, input string name, input int dist_edge);
      int exp_edge = (exp_k < 0) ? 2 * (1 << NV) : 2 * (exp_k + 1);
      int fin      = (exp_k < 0) ? (1 << NV) - 1 : exp_k;
      int got      = -1;
      for (int e = 1; e <= 600; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (e == dist_edge) begin
            cfg_we = 1'b1; cfg_clause = 4'd0; cfg_lit = 2'd0; cfg_var = 3'd0; cfg_neg = 1'b0;
            start = 1'b1;
         end else if (e == dist_edge + 1) begin
            cfg_we = 1'b0; start = 1'b0;
         end
         if (done === 1'b1) begin
            got = e;
            break;
         end
         if (e % 2 == 1) begin
            checks++;
            if (clauses_out !== model_encode((e - 1) / 2) || busy !== 1'b1) begin
               failures++;
               $display("FAIL %s_vec@%0d: clauses_out=%h busy=%b, required %h busy=1",
                        name, e, clauses_out, busy, model_encode((e - 1) / 2));
            end
         end
      end
      checks++;
      if (got != exp_edge) begin
         failures++;
         $display("FAIL %s_done_edge: done at edge %0d, required %0d", name, got, exp_edge);
      end
      if (got > 0) begin
         checks++;
         if (sat !== (exp_k >= 0) || assignment !== ((exp_k >= 0) ? NV'(exp_k) : '0) ||
             clauses_out !== model_encode(fin) || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_result: sat=%b assignment=%h clauses_out=%h busy=%b, required sat=%b assignment=%h clauses_out=%h busy=0",
                     name, sat, assignment, clauses_out, busy, exp_k >= 0,
                     (exp_k >= 0) ? NV'(exp_k) : NV'(0), model_encode(fin));
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || sat !== (exp_k >= 0)) begin
            failures++;
            $display("FAIL %s_after_done: done=%b busy=%b sat=%b, required done=0 busy=0 sat=%b",
                     name, done, busy, sat, exp_k >= 0);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_clear();
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sat !== 1'b0 || assignment !== '0 || clauses_out !== '0) begin
         failures++;
         $display("FAIL reset: busy=%b done=%b sat=%b assignment=%h clauses_out=%h, required all 0",
                  busy, done, sat, assignment, clauses_out);
      end
      rst = 1'b0;
   endtask

   task automatic test_default_table();
      start_search("default");
      wait_done(model_solve(), "default", -1);
   endtask

   task automatic test_unsat();
      set_clause(0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      set_clause(1, 0, 1'b1, 0, 1'b1, 0, 1'b1);
      for (int c = 2; c < NC; c++) set_clause(c, 1, 1'b0, 1, 1'b0, 1, 1'b0);
      start_search("unsat");
      wait_done(model_solve(), "unsat", -1);
   endtask

   task automatic test_encoding();
      // Clause 3 = (x2, ~x5, x0) on the UNSAT table: all 256 vectors are driven and checked.
      set_clause(3, 2, 1'b0, 5, 1'b1, 0, 1'b0);
      start_search("encoding");
      wait_done(model_solve(), "encoding", -1);
   endtask

   task automatic test_sat_x7();
      for (int c = 0; c < NC; c++) set_clause(c, 7, 1'b0, 7, 1'b0, 7, 1'b0);
      start_search("sat_x7");
      wait_done(model_solve(), "sat_x7", -1);
   endtask

   task automatic test_reset_mid();
      start_search("reset_mid");
      repeat (99) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      model_clear();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sat !== 1'b0 || clauses_out !== '0 || assignment !== '0) begin
         failures++;
         $display("FAIL reset_mid: busy=%b done=%b sat=%b clauses_out=%h assignment=%h, required all 0",
                  busy, done, sat, clauses_out, assignment);
      end
      rst = 1'b0;
      start_search("after_reset");
      wait_done(model_solve(), "after_reset", -1);
   endtask

   task automatic test_busy_ignore();
      set_clause(0, 7, 1'b0, 7, 1'b0, 7, 1'b0);
      for (int c = 1; c < NC; c++) set_clause(c, 0, 1'b0, 0, 1'b1, 0, 1'b0);
      // The disturbing write would make clause 0 satisfiable by x0; it must not land.
      start_search("busy_ignore");
      wait_done(model_solve(), "busy_ignore", 51);
      start_search("busy_rerun");
      wait_done(model_solve(), "busy_rerun", -1);
   endtask

   task automatic test_cfg_with_start();
      for (int c = 0; c < NC; c++) set_clause(c, 0, 1'b0, 0, 1'b1, 0, 1'b0);
      set_clause(2, 1, 1'b0, 2, 1'b0, 2, 1'b0);
      write_lit(2, 3, 0, 1'b0);   // out-of-range literal slot, dropped
      @(negedge clk);
      cfg_we = 1'b1; cfg_clause = 4'd2; cfg_lit = 2'd0; cfg_var = 3'd0; cfg_neg = 1'b0;
      start = 1'b1;
      model_write(2, 0, 0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      cfg_we = 1'b0; start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL cfg_start_accept: busy=%b, required 1", busy);
      end
      wait_done(model_solve(), "cfg_start", -1);
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         for (int c = 0; c < NC; c++)
            set_clause(c, int'($urandom_range(NV - 1)), 1'($urandom), int'($urandom_range(NV - 1)),
                       1'($urandom), int'($urandom_range(NV - 1)), 1'($urandom));
         start_search("random");
         wait_done(model_solve(), "random", -1);
      end
   endtask

   initial begin
      test_reset();
      test_default_table();
      test_unsat();
      test_encoding();
      test_sat_x7();
      test_reset_mid();
      test_busy_ignore();
      test_cfg_with_start();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
